cache_axi_bridge: RTL and testbench



---
 rtl/cache_axi_bridge_pkg.sv | 28 ++
 rtl/cache_axi_bridge_wr_buffer.sv | 126 ++++++++++++
 rtl/cache_axi_bridge.sv | 174 +++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_bridge_pkg
// Brief    : Shared type codes, AXI constants and length/size helpers for the
//            cache-to-AXI bridge.
// Revision : 1.0 - initial release
// ============================================================================
package cache_axi_bridge_pkg;

    localparam logic [2:0] c_rd_byte        = 3'b000;
    localparam logic [2:0] c_rd_half        = 3'b001;
    localparam logic [2:0] c_rd_word        = 3'b010;
    localparam logic [2:0] c_rd_line        = 3'b100;
    localparam logic [1:0] c_axi_burst_incr = 2'b01;
    localparam int         c_line_beats     = 4;
    localparam logic [3:0] c_ic_id          = 4'd0;
    localparam logic [3:0] c_dc_id          = 4'd1;

    function automatic logic [7:0] axi_len(input logic [2:0] typ, input int beats);
        return (typ == c_rd_line) ? 8'(beats - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] typ);
        return (typ == c_rd_line) ? 3'd2 : {1'b0, typ[1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_buffer
// Brief    : Single-entry write buffer: AW/W/B sequencing, line beat counter
//            and same-line hazard compare against the data-cache read address.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_buffer
    import cache_axi_bridge_pkg::*;
#(
    parameter int         LINE_BYTES = 16,
    parameter logic [3:0] DC_ID      = c_dc_id
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dc_wr_req,
    input  logic [2:0]              dc_wr_type,
    input  logic [31:0]             dc_wr_addr,
    input  logic [3:0]              dc_wr_wstrb,
    input  logic [LINE_BYTES*8-1:0] dc_wr_data,
    output logic                    dc_wr_rdy,
    input  logic [31:0]             dc_rd_addr,
    output logic                    dc_rd_hazard,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int c_beats = LINE_BYTES / 4;
    localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_off   = $clog2(LINE_BYTES);

    localparam logic [1:0] c_w_idle = 2'd0;
    localparam logic [1:0] c_w_send = 2'd1;
    localparam logic [1:0] c_w_resp = 2'd2;

    logic [1:0]              r_state;
    logic [31:0]             r_addr;
    logic [2:0]              r_type;
    logic [3:0]              r_strb;
    logic [LINE_BYTES*8-1:0] r_data;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    w_is_line;
    logic                    w_last_beat;

    assign w_is_line   = (r_type == c_rd_line);
    assign w_last_beat = !w_is_line || (r_cnt == c_cnt_w'(c_beats - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_w_idle;
            r_addr    <= '0;
            r_type    <= '0;
            r_strb    <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            case (r_state)
                c_w_idle: begin
                    if (dc_wr_req) begin
                        r_addr    <= dc_wr_addr;
                        r_type    <= dc_wr_type;
                        r_strb    <= dc_wr_wstrb;
                        r_data    <= dc_wr_data;
                        r_cnt     <= '0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= c_w_send;
                    end
                end
                c_w_send: begin
                    // The valid flags double as the per-channel "still owed" markers.
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready) begin
                        if (w_last_beat) begin
                            r_wvalid <= 1'b0;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if ((!r_awvalid || awready) && (!r_wvalid || (wready && w_last_beat)))
                        r_state <= c_w_resp;
                end
                c_w_resp: begin
                    if (bvalid) r_state <= c_w_idle;
                end
                default: r_state <= c_w_idle;
            endcase
        end
    end

    assign dc_wr_rdy    = (r_state == c_w_idle);
    assign bready       = (r_state == c_w_resp);
    assign dc_rd_hazard = (r_state != c_w_idle) && (dc_rd_addr[31:c_off] == r_addr[31:c_off]);

    assign awid    = DC_ID;
    assign awaddr  = r_addr;
    assign awlen   = axi_len(r_type, c_beats);
    assign awsize  = axi_size(r_type);
    assign awburst = c_axi_burst_incr;
    assign awvalid = r_awvalid;

    // Single writes always ride on slice 0, which holds the uncached word.
    assign wdata  = r_data[r_cnt*32 +: 32];
    assign wstrb  = w_is_line ? 4'hF : r_strb;
    assign wlast  = r_wvalid && w_last_beat;
    assign wvalid = r_wvalid;

endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_bridge
// Brief    : Bridges I/D cache read ports and the D-cache write-back port onto
//            one 32-bit AXI4 master; read FSM, arbitration and R routing.
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int         LINE_BYTES = 16,
    parameter logic [3:0] IC_ID      = c_ic_id,
    parameter logic [3:0] DC_ID      = c_dc_id
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_rd_req,
    input  logic [2:0]              ic_rd_type,
    input  logic [31:0]             ic_rd_addr,
    output logic                    ic_rd_rdy,
    output logic                    ic_ret_valid,
    output logic                    ic_ret_last,
    output logic [31:0]             ic_ret_data,
    input  logic                    dc_rd_req,
    input  logic [2:0]              dc_rd_type,
    input  logic [31:0]             dc_rd_addr,
    output logic                    dc_rd_rdy,
    output logic                    dc_ret_valid,
    output logic                    dc_ret_last,
    output logic [31:0]             dc_ret_data,
    input  logic                    dc_wr_req,
    input  logic [2:0]              dc_wr_type,
    input  logic [31:0]             dc_wr_addr,
    input  logic [3:0]              dc_wr_wstrb,
    input  logic [LINE_BYTES*8-1:0] dc_wr_data,
    output logic                    dc_wr_rdy,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int c_beats = LINE_BYTES / 4;

    localparam logic [1:0] c_r_idle = 2'd0;
    localparam logic [1:0] c_r_ar   = 2'd1;
    localparam logic [1:0] c_r_data = 2'd2;

    logic [1:0]  r_rstate;
    logic [31:0] r_araddr;
    logic [2:0]  r_artype;
    logic        r_is_dc;
    logic        r_arvalid;
    logic        w_hazard;
    logic        w_idle;
    logic        w_beat_ok;
    logic        w_unused;

    assign w_idle    = (r_rstate == c_r_idle);
    // A hazard-blocked data read still holds the instruction cache off.
    assign dc_rd_rdy = w_idle && !w_hazard;
    assign ic_rd_rdy = w_idle && !dc_rd_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= c_r_idle;
            r_araddr  <= '0;
            r_artype  <= '0;
            r_is_dc   <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_rstate)
                c_r_idle: begin
                    if (dc_rd_req && dc_rd_rdy) begin
                        r_araddr  <= dc_rd_addr;
                        r_artype  <= dc_rd_type;
                        r_is_dc   <= 1'b1;
                        r_arvalid <= 1'b1;
                        r_rstate  <= c_r_ar;
                    end else if (ic_rd_req && ic_rd_rdy) begin
                        r_araddr  <= ic_rd_addr;
                        r_artype  <= ic_rd_type;
                        r_is_dc   <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_rstate  <= c_r_ar;
                    end
                end
                c_r_ar: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rstate  <= c_r_data;
                    end
                end
                c_r_data: begin
                    if (rvalid && rlast) r_rstate <= c_r_idle;
                end
                default: r_rstate <= c_r_idle;
            endcase
        end
    end

    assign arid    = r_is_dc ? DC_ID : IC_ID;
    assign araddr  = r_araddr;
    assign arlen   = axi_len(r_artype, c_beats);
    assign arsize  = axi_size(r_artype);
    assign arburst = c_axi_burst_incr;
    assign arvalid = r_arvalid;
    assign rready  = (r_rstate == c_r_data);

    // Beats with a foreign rid are still accepted but never forwarded.
    assign w_beat_ok    = rready && rvalid && (rid == arid);
    assign dc_ret_valid = w_beat_ok && r_is_dc;
    assign ic_ret_valid = w_beat_ok && !r_is_dc;
    assign dc_ret_last  = dc_ret_valid && rlast;
    assign ic_ret_last  = ic_ret_valid && rlast;
    assign dc_ret_data  = dc_ret_valid ? rdata : '0;
    assign ic_ret_data  = ic_ret_valid ? rdata : '0;
    assign w_unused     = ^rresp;

    axi_wr_buffer #(
        .LINE_BYTES (LINE_BYTES),
        .DC_ID      (DC_ID)
    ) u_wr_buffer (
        .clk          (clk),
        .reset        (reset),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_type   (dc_wr_type),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_wstrb  (dc_wr_wstrb),
        .dc_wr_data   (dc_wr_data),
        .dc_wr_rdy    (dc_wr_rdy),
        .dc_rd_addr   (dc_rd_addr),
        .dc_rd_hazard (w_hazard),
        .awid         (awid),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_bridge
// Brief    : Self-checking bench: AXI slave with random delays, transaction
//            logs compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BEATS = LINE_BYTES / 4;

    logic clk, reset;
    logic ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [2:0] ic_rd_type;
    logic [31:0] ic_rd_addr, ic_ret_data;
    logic dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [2:0] dc_rd_type;
    logic [31:0] dc_rd_addr, dc_ret_data;
    logic dc_wr_req, dc_wr_rdy;
    logic [2:0] dc_wr_type;
    logic [31:0] dc_wr_addr;
    logic [3:0] dc_wr_wstrb;
    logic [LINE_BYTES*8-1:0] dc_wr_data;
    logic [3:0] arid, awid, rid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    cache_axi_bridge #(.LINE_BYTES(LINE_BYTES), .IC_ID(4'd0), .DC_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    // Slave knobs, changed only while the bus is quiet.
    int ar_delay = 0, r_gap = 0, aw_delay = 0, b_delay = 0, w_mode = 0;
    logic [31:0] mem_key = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ mem_key;
    endfunction

    function automatic logic [63:0] ax_entry(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [7:0] len, input logic [2:0] size,
                                             input logic [1:0] burst);
        return {15'b0, id, addr, len, size, burst};
    endfunction

    function automatic logic [7:0] exp_len(input logic [2:0] typ);
        return (typ == 3'b100) ? 8'(LINE_BEATS - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] typ);
        return (typ == 3'b100) ? 3'd2 : {1'b0, typ[1:0]};
    endfunction

    logic [63:0] ar_log[$], aw_log[$], w_log[$], obs_dc[$], obs_ic[$];
    logic [63:0] exp_ar[$], exp_aw[$], exp_w[$], exp_dc[$], exp_ic[$];
    int aw_cnt = 0, wl_cnt = 0, b_cnt = 0, b_hs = 0, n_wr_exp = 0;
    int b_fire_cyc = 0, dc_last_cyc = 0;
    bit prev_b = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (arvalid && arready) ar_log.push_back(ax_entry(arid, araddr, arlen, arsize, arburst));
            if (awvalid && awready) begin
                aw_log.push_back(ax_entry(awid, awaddr, awlen, awsize, awburst));
                aw_cnt++;
            end
            if (wvalid && wready) begin
                w_log.push_back({27'b0, wdata, wstrb, wlast});
                if (wlast) wl_cnt++;
            end
            if (dc_ret_valid) begin
                obs_dc.push_back({31'b0, dc_ret_data, dc_ret_last});
                if (dc_ret_last) dc_last_cyc = cyc;
            end
            if (ic_ret_valid) obs_ic.push_back({31'b0, ic_ret_data, ic_ret_last});
            if (prev_b) check("wr_rdy_after_b", 64'(dc_wr_rdy), 64'd1);
            prev_b = bvalid && bready;
            if (prev_b) begin
                b_fire_cyc = cyc;
                b_hs++;
                check("wr_rdy_in_resp", 64'(dc_wr_rdy), 64'd0);
            end
        end else begin
            prev_b = 0;
        end
    end

    // AR + R responder: beats of a burst come from consecutive word addresses.
    initial begin
        logic [31:0] s_addr;
        logic [7:0]  s_len;
        logic [3:0]  s_id;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
        forever begin
            @(posedge clk); #1;
            if (arvalid && !reset) begin
                repeat (ar_delay) begin @(posedge clk); #1; end
                arready = 1;
                s_addr = araddr; s_len = arlen; s_id = arid;
                @(posedge clk); #1;
                arready = 0;
                for (int i = 0; i <= int'(s_len); i++) begin
                    repeat (r_gap) begin @(posedge clk); #1; end
                    rvalid = 1; rid = s_id; rdata = mem_word(s_addr + 32'(4 * i));
                    rlast = (i == int'(s_len)); rresp = 2'($urandom);
                    @(posedge clk); #1;
                    rvalid = 0; rlast = 0;
                end
            end
        end
    end

    initial begin
        awready = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid && !reset) begin
                repeat (aw_delay) begin @(posedge clk); #1; end
                awready = 1;
                @(posedge clk); #1;
                awready = 0;
            end
        end
    end

    initial begin
        wready = 0;
        forever begin
            @(posedge clk); #1;
            case (w_mode)
                0: wready = 1;
                1: wready = ~wready;
                2: wready = 1'($urandom);
                default: wready = 0;
            endcase
        end
    end

    initial begin
        bvalid = 0;
        forever begin
            @(posedge clk); #1;
            if (aw_cnt > b_cnt && wl_cnt > b_cnt) begin
                repeat (b_delay) begin @(posedge clk); #1; end
                bvalid = 1;
                begin : b_wait
                    for (int k = 0; k < 300; k++) begin
                        @(negedge clk);
                        if (bready) disable b_wait;
                    end
                    check("b_handshake_timeout", 64'(bready), 64'd1);
                end
                @(posedge clk); #1;
                bvalid = 0;
                b_cnt++;
            end
        end
    end

    task automatic issue_read(input bit is_dc, input logic [31:0] addr, input logic [2:0] typ,
                              output int waited, output int acc_cyc);
        int beats;
        bit ok;
        @(posedge clk); #1;
        if (is_dc) begin dc_rd_req = 1; dc_rd_addr = addr; dc_rd_type = typ; end
        else       begin ic_rd_req = 1; ic_rd_addr = addr; ic_rd_type = typ; end
        waited = 0; ok = 0; acc_cyc = 0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (is_dc ? dc_rd_rdy : ic_rd_rdy) begin ok = 1; acc_cyc = cyc; end
            else waited++;
        end
        if (!ok) check("rd_accept_timeout", 64'd0, 64'd1);
        exp_ar.push_back(ax_entry(is_dc ? 4'd1 : 4'd0, addr, exp_len(typ), exp_size(typ), 2'b01));
        beats = (typ == 3'b100) ? LINE_BEATS : 1;
        for (int i = 0; i < beats; i++) begin
            if (is_dc) exp_dc.push_back({31'b0, mem_word(addr + 32'(4 * i)), i == beats - 1});
            else       exp_ic.push_back({31'b0, mem_word(addr + 32'(4 * i)), i == beats - 1});
        end
        @(posedge clk); #1;
        if (is_dc) dc_rd_req = 0; else ic_rd_req = 0;
        check("arvalid_rise", 64'(arvalid), 64'd1);
    endtask

    task automatic issue_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                               input logic [LINE_BYTES*8-1:0] data);
        bit ok = 0;
        @(posedge clk); #1;
        dc_wr_req = 1; dc_wr_addr = addr; dc_wr_type = typ; dc_wr_wstrb = strb; dc_wr_data = data;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (dc_wr_rdy) ok = 1;
        end
        if (!ok) check("wr_accept_timeout", 64'd0, 64'd1);
        exp_aw.push_back(ax_entry(4'd1, addr, exp_len(typ), exp_size(typ), 2'b01));
        if (typ == 3'b100) begin
            for (int i = 0; i < LINE_BEATS; i++)
                exp_w.push_back({27'b0, data[i*32 +: 32], 4'hF, i == LINE_BEATS - 1});
        end else begin
            exp_w.push_back({27'b0, data[31:0], strb, 1'b1});
        end
        n_wr_exp++;
        @(posedge clk); #1;
        dc_wr_req = 0;
        check("awvalid_rise", 64'(awvalid), 64'd1);
        check("wvalid_rise", 64'(wvalid), 64'd1);
    endtask

    task automatic cmp_q(input string tag, inout logic [63:0] o[$], inout logic [63:0] e[$]);
        check({tag, "_count"}, 64'(o.size()), 64'(e.size()));
        for (int i = 0; i < o.size() && i < e.size(); i++) check(tag, o[i], e[i]);
        o.delete(); e.delete();
    endtask

    task automatic settle(input string tag);
        bit done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = ic_rd_rdy && !dc_rd_req && dc_wr_rdy && b_hs == n_wr_exp &&
                   obs_dc.size() >= exp_dc.size() && obs_ic.size() >= exp_ic.size() &&
                   w_log.size() >= exp_w.size() && ar_log.size() >= exp_ar.size();
        end
        if (!done) check({tag, "_settle_timeout"}, 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        cmp_q({tag, "_ar"}, ar_log, exp_ar);
        cmp_q({tag, "_aw"}, aw_log, exp_aw);
        cmp_q({tag, "_w"}, w_log, exp_w);
        cmp_q({tag, "_dcret"}, obs_dc, exp_dc);
        cmp_q({tag, "_icret"}, obs_ic, exp_ic);
    endtask

    function automatic logic [2:0] rand_type();
        case ($urandom_range(0, 3))
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    initial begin
        int wt, ac, wt2, ac2;
        logic [31:0] a;
        logic [2:0] t;
        reset = 1;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valids", {58'b0, arvalid, awvalid, wvalid, rready, bready, dc_ret_valid | ic_ret_valid}, 64'd0);
        check("rst_rdys", {61'b0, dc_rd_rdy, ic_rd_rdy, dc_wr_rdy}, 64'h7);
        check("rst_addr", {araddr, awaddr}, 64'd0);
        #1 reset = 0;

        // Data-cache line read with delayed arready and known beat data.
        mem_key = 32'h070000A4; ar_delay = 2;
        issue_read(1, 32'h1C000010, 3'b100, wt, ac);
        settle("dline");

        // Simultaneous requests: data cache wins, ic follows right after rlast.
        ar_delay = 0; mem_key = $urandom;
        fork
            issue_read(1, 32'h00004000, 3'b100, wt, ac);
            issue_read(0, 32'h00008004, 3'b010, wt2, ac2);
            begin
                @(posedge clk); @(negedge clk);
                check("arb_dc_rdy", 64'(dc_rd_rdy), 64'd1);
                check("arb_ic_rdy", 64'(ic_rd_rdy), 64'd0);
            end
        join
        check("ic_after_rlast", 64'(ac2), 64'(dc_last_cyc + 1));
        settle("arb");

        // Dirty line write with toggling wready.
        w_mode = 1;
        issue_write(32'h00001230, 3'b100, 4'h0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        settle("lwrite");

        // Uncached partial word write.
        w_mode = 0;
        issue_write(32'hBFAF8000, 3'b010, 4'b0011, {96'h1234_5678_9ABC_DEF0_1111_2222, 32'hDEADBEEF});
        settle("uwrite");

        // Hazard window: other line passes, same line waits until after B.
        b_delay = 10;
        issue_write(32'h00001230, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
        issue_read(1, 32'h00002230, 3'b010, wt, ac);
        check("nohaz_immediate", 64'(wt), 64'd0);
        fork
            issue_read(1, 32'h00001238, 3'b010, wt, ac);
            begin
                @(posedge clk); @(negedge clk);
                check("haz_dc_rdy", 64'(dc_rd_rdy), 64'd0);
                check("haz_ic_rdy", 64'(ic_rd_rdy), 64'd0);
            end
        join
        check("haz_release", 64'(ac), 64'(b_fire_cyc + 1));
        settle("hazard");

        // Randomized traffic, sometimes a read and a write in flight together.
        for (int it = 0; it < 24; it++) begin
            ar_delay = $urandom_range(0, 3); r_gap = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            w_mode = 2; mem_key = $urandom;
            a = 32'h1000 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
            t = rand_type();
            case ($urandom_range(0, 3))
                0: issue_read(1, a, t, wt, ac);
                1: issue_read(0, a, t, wt, ac);
                2: issue_write(a, t, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
                default: fork
                    issue_write(a, t, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
                    issue_read(1, 32'h1000 + 32'($urandom_range(0, 3) * 16), rand_type(), wt, ac);
                join
            endcase
            settle("rand");
        end

        // Reset in the middle of R_DATA and W_SEND.
        ar_delay = 0; r_gap = 30; aw_delay = 0; b_delay = 0; w_mode = 3;
        fork
            issue_write(32'h00003000, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
            issue_read(1, 32'h00005000, 3'b100, wt, ac);
        join
        begin : wait_rdata
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (rready) disable wait_rdata;
            end
        end
        check("pre_rst_busy", {62'b0, rready, wvalid}, 64'h3);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_valids", {58'b0, arvalid, awvalid, wvalid, rready, bready, dc_ret_valid | ic_ret_valid}, 64'd0);
        check("mid_rst_rdys", {61'b0, dc_rd_rdy, ic_rd_rdy, dc_wr_rdy}, 64'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
